// File: rtl/image_pkg.sv
// ============================================================================
// image_pkg : shared sizes, pixel type and timing helper for image_scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package image_pkg;

    localparam int IMG_W_LOG2 = 6;
    localparam int IMG_H_LOG2 = 5;
    localparam int ROM_AW     = 11;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb666_t;

    function automatic int total(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_delay.sv
// ============================================================================
// video_delay : fixed-depth shift register with synchronous reset-to-value
// Rev 1.0
// ============================================================================
`default_nettype none

module video_delay #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= RST_VAL;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/image_scanner.sv
// ============================================================================
// image_scanner : raster timing, scaled 64x32 ROM fetch, latency-aligned RGB666
// Optional IMAGE_SCANNER_BORDER_EN: white one-pixel ring around the image
// Rev 1.0
// ============================================================================
`default_nettype none

module image_scanner
    import image_pkg::*;
#(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int          SCALE_LOG2  = 3,
    parameter int          X_OFF       = 64,
    parameter int          Y_OFF       = 112,
    parameter int          ROM_LATENCY = 2,
    parameter logic [17:0] BG_COLOR    = 18'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_ad,
    input  logic [17:0]       rom_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [5:0]        r,
    output logic [5:0]        g,
    output logic [5:0]        b
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_CW    = ($clog2(H_TOTAL + 1) > IMG_W_LOG2) ? $clog2(H_TOTAL + 1) : IMG_W_LOG2;
    localparam int V_CW    = ($clog2(V_TOTAL + 1) > IMG_H_LOG2) ? $clog2(V_TOTAL + 1) : IMG_H_LOG2;
    localparam int WIN_W   = 1 << (IMG_W_LOG2 + SCALE_LOG2);
    localparam int WIN_H   = 1 << (IMG_H_LOG2 + SCALE_LOG2);

    localparam logic [H_CW-1:0] c_H_LAST = H_CW'(H_TOTAL - 1);
    localparam logic [H_CW-1:0] c_H_ACT  = H_CW'(H_ACTIVE);
    localparam logic [H_CW-1:0] c_HS_LO  = H_CW'(H_ACTIVE + H_FP);
    localparam logic [H_CW-1:0] c_HS_HI  = H_CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_CW-1:0] c_X_LO   = H_CW'(X_OFF);
    localparam logic [H_CW-1:0] c_X_HI   = H_CW'(X_OFF + WIN_W);
    localparam logic [V_CW-1:0] c_V_LAST = V_CW'(V_TOTAL - 1);
    localparam logic [V_CW-1:0] c_V_ACT  = V_CW'(V_ACTIVE);
    localparam logic [V_CW-1:0] c_VS_LO  = V_CW'(V_ACTIVE + V_FP);
    localparam logic [V_CW-1:0] c_VS_HI  = V_CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_CW-1:0] c_Y_LO   = V_CW'(Y_OFF);
    localparam logic [V_CW-1:0] c_Y_HI   = V_CW'(Y_OFF + WIN_H);

    localparam int F_HS   = 0;
    localparam int F_VS   = 1;
    localparam int F_DE   = 2;
    localparam int F_WIN  = 3;
`ifdef IMAGE_SCANNER_BORDER_EN
    localparam int F_RING = 4;
    localparam int FLAG_W = 5;
`else
    localparam int FLAG_W = 4;
`endif

    if ((X_OFF < 0) || (Y_OFF < 0) || (X_OFF + WIN_W > H_ACTIVE) || (Y_OFF + WIN_H > V_ACTIVE))
    begin : g_win_check
        $fatal(1, "image_scanner: image window does not fit inside the active area");
    end

    logic [H_CW-1:0]       h_cnt_q, h_cnt_d;
    logic [V_CW-1:0]       v_cnt_q, v_cnt_d;
    logic [ROM_AW-1:0]     rom_ad_q;
    logic                  hsync_q, vsync_q, de_q;
    rgb666_t               rgb_q, rgb_d;

    logic                  w_hs, w_vs, w_de, w_in_win;
    logic [H_CW-1:0]       w_h_rel;
    logic [V_CW-1:0]       w_v_rel;
    logic [IMG_W_LOG2-1:0] w_col;
    logic [IMG_H_LOG2-1:0] w_row;
    logic [FLAG_W-1:0]     w_flags, w_dly;

    always_comb begin
        h_cnt_d = h_cnt_q + H_CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_V_LAST) ? '0 : v_cnt_q + V_CW'(1);
        end
    end

    assign w_hs     = (h_cnt_q >= c_HS_LO) && (h_cnt_q < c_HS_HI);
    assign w_vs     = (v_cnt_q >= c_VS_LO) && (v_cnt_q < c_VS_HI);
    assign w_de     = (h_cnt_q < c_H_ACT) && (v_cnt_q < c_V_ACT);
    assign w_in_win = w_de && (h_cnt_q >= c_X_LO) && (h_cnt_q < c_X_HI)
                           && (v_cnt_q >= c_Y_LO) && (v_cnt_q < c_Y_HI);

    // Offsets wrap outside the window, but the address is forced to 0 there.
    assign w_h_rel = h_cnt_q - c_X_LO;
    assign w_v_rel = v_cnt_q - c_Y_LO;
    assign w_col   = IMG_W_LOG2'(w_h_rel >> SCALE_LOG2);
    assign w_row   = IMG_H_LOG2'(w_v_rel >> SCALE_LOG2);

`ifdef IMAGE_SCANNER_BORDER_EN
    logic [H_CW:0] w_h_p1;
    logic [V_CW:0] w_v_p1;
    logic          w_ring;

    // Compare counter+1 against the offset so a zero offset cannot underflow.
    assign w_h_p1  = {1'b0, h_cnt_q} + (H_CW+1)'(1);
    assign w_v_p1  = {1'b0, v_cnt_q} + (V_CW+1)'(1);
    assign w_ring  = w_de && !w_in_win
                     && (w_h_p1 >= (H_CW+1)'(X_OFF)) && (h_cnt_q <= c_X_HI)
                     && (w_v_p1 >= (V_CW+1)'(Y_OFF)) && (v_cnt_q <= c_Y_HI);
    assign w_flags = {w_ring, w_in_win, w_de, w_vs, w_hs};
`else
    assign w_flags = {w_in_win, w_de, w_vs, w_hs};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            rom_ad_q <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            rom_ad_q <= w_in_win ? {w_row, w_col} : '0;
        end
    end

    // One stage for the address register plus ROM_LATENCY for the ROM itself.
    video_delay #(
        .WIDTH   (FLAG_W),
        .DEPTH   (ROM_LATENCY + 1),
        .RST_VAL ('0)
    ) u_flag_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (w_flags),
        .q_o   (w_dly)
    );

    always_comb begin
        rgb_d = '0;
        if (w_dly[F_DE]) begin
            if (w_dly[F_WIN]) begin
                rgb_d = rom_data;
            end
`ifdef IMAGE_SCANNER_BORDER_EN
            else if (w_dly[F_RING]) begin
                rgb_d = 18'h3FFFF;
            end
`endif
            else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= w_dly[F_HS] ? SYNC_POL : ~SYNC_POL;
            vsync_q <= w_dly[F_VS] ? SYNC_POL : ~SYNC_POL;
            de_q    <= w_dly[F_DE];
            rgb_q   <= rgb_d;
        end
    end

    assign rom_ad = rom_ad_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign de     = de_q;
    assign r      = rgb_q.r;
    assign g      = rgb_q.g;
    assign b      = rgb_q.b;

endmodule

`default_nettype wire

// File: tb/tb_image_scanner.sv
// ============================================================================
// tb_image_scanner : directed checks on three reduced-timing image_scanner builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_image_scanner;

    localparam logic [17:0] BG_A = 18'h15555;
    localparam logic [17:0] BG_B = 18'h2AAAA;
`ifdef IMAGE_SCANNER_BORDER_EN
    localparam logic [17:0] RING_A = 18'h3FFFF;
    localparam logic [17:0] RING_B = 18'h3FFFF;
`else
    localparam logic [17:0] RING_A = BG_A;
    localparam logic [17:0] RING_B = BG_B;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] rom_ad_a, rom_ad_b, rom_ad_c;
    logic [17:0] rom_data_a, rom_data_b, rom_data_c;
    logic        hsync_a, vsync_a, de_a, hsync_b, vsync_b, de_b, hsync_c, vsync_c, de_c;
    logic [5:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic [17:0] pix_a, pix_b, pix_c;
    assign pix_a = {r_a, g_a, b_a};
    assign pix_b = {r_b, g_b, b_b};
    assign pix_c = {r_c, g_c, b_c};

    // A: 192x88 total, scale 2, latency 2, active-low sync
    image_scanner #(
        .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(80), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b0), .SCALE_LOG2(1), .X_OFF(16), .Y_OFF(8),
        .ROM_LATENCY(2), .BG_COLOR(BG_A)
    ) u_dut_a (
        .clk(clk), .reset(reset), .rom_ad(rom_ad_a), .rom_data(rom_data_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .r(r_a), .g(g_a), .b(b_a)
    );

    // B: 96x47 total, scale 1, latency 4, active-high sync
    image_scanner #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .SCALE_LOG2(0), .X_OFF(8), .Y_OFF(4),
        .ROM_LATENCY(4), .BG_COLOR(BG_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .rom_ad(rom_ad_b), .rom_data(rom_data_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .r(r_b), .g(g_b), .b(b_b)
    );

    // C: same timing as B, latency 1, active-low sync
    image_scanner #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .SCALE_LOG2(0), .X_OFF(8), .Y_OFF(4),
        .ROM_LATENCY(1), .BG_COLOR(18'h0)
    ) u_dut_c (
        .clk(clk), .reset(reset), .rom_ad(rom_ad_c), .rom_data(rom_data_c),
        .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .r(r_c), .g(g_c), .b(b_c)
    );

    // ROM models: word = address, delayed by each build's latency
    logic [10:0] pa [2];
    logic [10:0] pb [4];
    logic [10:0] pc;
    always @(posedge clk) begin
        pa[0] <= rom_ad_a;
        pa[1] <= pa[0];
        pb[0] <= rom_ad_b;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
        pb[3] <= pb[2];
        pc    <= rom_ad_c;
    end
    assign rom_data_a = {7'd0, pa[1]};
    assign rom_data_b = {7'd0, pb[3]};
    assign rom_data_c = {7'd0, pc};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit count_en = 1'b0;
    int hs_a = 0, vs_a = 0, de_n_a = 0;
    int hs_b = 0, vs_b = 0, de_n_b = 0;
    int hs_c = 0, de_n_c = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc = rising edges since the last reset edge; sampling is 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (count_en) begin
                if (cyc >= 4 && cyc < 33796) begin
                    if (!hsync_a) hs_a++;
                    if (!vsync_a) vs_a++;
                    if (de_a)     de_n_a++;
                end
                if (cyc >= 6 && cyc < 9030) begin
                    if (hsync_b) hs_b++;
                    if (vsync_b) vs_b++;
                    if (de_b)    de_n_b++;
                end
                if (cyc >= 3 && cyc < 9027) begin
                    if (!hsync_c) hs_c++;
                    if (de_c)     de_n_c++;
                end
            end
        end
    endtask

    task automatic advance_to(input int k);
        if (k > cyc) step(k - cyc);
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        check("rst rom_ad_a", 32'(rom_ad_a), 32'd0);
        check("rst hsync_a",  32'(hsync_a),  32'd1);
        check("rst vsync_a",  32'(vsync_a),  32'd1);
        check("rst de_a",     32'(de_a),     32'd0);
        check("rst rgb_a",    32'(pix_a),    32'd0);
        check("rst hsync_b",  32'(hsync_b),  32'd0);
        check("rst vsync_b",  32'(vsync_b),  32'd0);

        reset = 1'b0;
        cyc = 0;
        count_en = 1'b1;

        advance_to(2);  check("C de k2",  32'(de_c), 32'd0);
        advance_to(3);  check("A de k3",  32'(de_a), 32'd0);
                        check("C de k3",  32'(de_c), 32'd1);
        advance_to(4);  check("A de k4",  32'(de_a), 32'd1);
                        check("A px(0,0) bg", 32'(pix_a), 32'(BG_A));
        advance_to(5);  check("B de k5",  32'(de_b), 32'd0);
        advance_to(6);  check("B de k6",  32'(de_b), 32'd1);
        advance_to(82); check("C de end-1", 32'(de_c), 32'd1);
        advance_to(83); check("C de end",   32'(de_c), 32'd0);
        advance_to(85); check("B de end-1", 32'(de_b), 32'd1);
        advance_to(86); check("B de end",   32'(de_b), 32'd0);
                        check("C hs pre",   32'(hsync_c), 32'd1);
        advance_to(87); check("C hs start", 32'(hsync_c), 32'd0);
        advance_to(89); check("B hs pre",   32'(hsync_b), 32'd0);
        advance_to(90); check("B hs start", 32'(hsync_b), 32'd1);
        advance_to(97); check("B hs last",  32'(hsync_b), 32'd1);
        advance_to(98); check("B hs end",   32'(hsync_b), 32'd0);
        advance_to(163); check("A de end-1", 32'(de_a), 32'd1);
        advance_to(164); check("A de end",   32'(de_a), 32'd0);
        advance_to(171); check("A hs pre",   32'(hsync_a), 32'd1);
        advance_to(172); check("A hs start", 32'(hsync_a), 32'd0);

        advance_to(395); check("C px(8,4)",  32'(pix_c), 32'd0);
        advance_to(396); check("C px(9,4)",  32'(pix_c), 32'd1);
        advance_to(397); check("B px(7,4) ring", 32'(pix_b), 32'(RING_B));
        advance_to(398); check("B px(8,4)",  32'(pix_b), 32'd0);
                         check("B de(8,4)",  32'(de_b),  32'd1);
        advance_to(399); check("B px(9,4)",  32'(pix_b), 32'd1);

        advance_to(974);  check("A px(10,5) bg", 32'(pix_a), 32'(BG_A));
                          check("A rom_ad out", 32'(rom_ad_a), 32'd0);
        advance_to(1555); check("A px(15,8) ring", 32'(pix_a), 32'(RING_A));
                          check("A rom_ad(18,8)", 32'(rom_ad_a), 32'd1);
        advance_to(1556); check("A px(16,8)", 32'(pix_a), 32'd0);
                          check("A de(16,8)", 32'(de_a),  32'd1);
        advance_to(1557); check("A px(17,8)", 32'(pix_a), 32'd0);
        advance_to(1558); check("A px(18,8)", 32'(pix_a), 32'd1);
        advance_to(1559); check("A px(19,8)", 32'(pix_a), 32'd1);
        advance_to(1560); check("A px(20,8)", 32'(pix_a), 32'd2);
        advance_to(1940); check("A px(16,10)", 32'(pix_a), 32'h40);
        advance_to(2094); check("A blank rgb", 32'(pix_a), 32'd0);
                          check("A blank de",  32'(de_a),  32'd0);
                          check("A blank hs",  32'(hsync_a), 32'd0);
        advance_to(3437); check("B px(71,35)", 32'(pix_b), 32'h7FF);
        advance_to(3438); check("B px(72,35) ring", 32'(pix_b), 32'(RING_B));
        advance_to(7828); check("A px(144,40) ring", 32'(pix_a), 32'(RING_A));
        advance_to(13779); check("A px(143,71)", 32'(pix_a), 32'h7FF);
        advance_to(13780); check("A px(144,71) ring", 32'(pix_a), 32'(RING_A));
        advance_to(14554); check("A px(150,75) bg", 32'(pix_a), 32'(BG_A));
        advance_to(15747); check("A vs pre",   32'(vsync_a), 32'd1);
        advance_to(15748); check("A vs start", 32'(vsync_a), 32'd0);

        advance_to(33796);
        count_en = 1'b0;
        check("A hsync low count", 32'(hs_a),   32'd2816);
        check("A vsync low count", 32'(vs_a),   32'd768);
        check("A de count",        32'(de_n_a), 32'd25600);
        check("B hsync act count", 32'(hs_b),   32'd752);
        check("B vsync act count", 32'(vs_b),   32'd384);
        check("B de count",        32'(de_n_b), 32'd6400);
        check("C hsync low count", 32'(hs_c),   32'd752);
        check("C de count",        32'(de_n_c), 32'd6400);

        // one-cycle reset at line 50, pixel 100 of the third frame of A
        advance_to(43496);
        reset = 1'b1;
        step(1);
        check("mid rst rom_ad_a", 32'(rom_ad_a), 32'd0);
        check("mid rst hsync_a",  32'(hsync_a),  32'd1);
        check("mid rst vsync_a",  32'(vsync_a),  32'd1);
        check("mid rst de_a",     32'(de_a),     32'd0);
        check("mid rst rgb_a",    32'(pix_a),    32'd0);
        check("mid rst hsync_b",  32'(hsync_b),  32'd0);
        check("mid rst de_c",     32'(de_c),     32'd0);
        reset = 1'b0;
        cyc = 0;
        advance_to(1);   check("post rst de_a k1",  32'(de_a),  32'd0);
                         check("post rst rgb_a k1", 32'(pix_a), 32'd0);
        advance_to(3);   check("post rst de_a k3",  32'(de_a),  32'd0);
        advance_to(4);   check("post rst de_a k4",  32'(de_a),  32'd1);
                         check("post rst px(0,0)",  32'(pix_a), 32'(BG_A));
        advance_to(171); check("post rst hs pre",   32'(hsync_a), 32'd1);
        advance_to(172); check("post rst hs start", 32'(hsync_a), 32'd0);
        advance_to(1555); check("post rst rom_ad", 32'(rom_ad_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/image_scanner.md
# image_scanner

Video front end that sits in front of `image_rom`. It generates raster timing, drives the 11-bit ROM address for a 64×32 image scaled into a fixed window, and consumes the pipelined 18-bit ROM word as one RGB666 pixel. It compensates for ROM read latency so that `hsync`/`vsync`/`de`/RGB leave the block cycle-aligned, ready for the serializer or LCD pins.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `SYNC_POL` 0: sync asserted level (0 = active-low).
- `SCALE_LOG2` 3: each image pixel is replicated 2^SCALE_LOG2 times in x and in y.
- `X_OFF` 64, `Y_OFF` 112: top-left of the image window, in active coordinates.
- `ROM_LATENCY` 2: cycles from `rom_ad` change to valid `rom_data`.
- `BG_COLOR` 18'h0: RGB666 value driven in the active area outside the window.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `rom_ad` out 11: image address `{row[4:0], col[5:0]}`; connects to `image_rom.ad`.
- `rom_data` in 18: from `image_rom.data`; bits `{R[17:12], G[11:6], B[5:0]}`.
- `hsync` out 1, `vsync` out 1: sync outputs at `SYNC_POL` when asserted.
- `de` out 1: active-video enable.
- `r` out 6, `g` out 6, `b` out 6: pixel colour.

## Operation
- `h_cnt` runs 0..H_TOTAL-1 (H_TOTAL = sum of the horizontal parameters). At H_TOTAL-1 it wraps to 0 and `v_cnt` increments. `v_cnt` wraps at V_TOTAL-1. Order within a line/frame: active, front porch, sync, back porch.
- `in_win` is true when `X_OFF ≤ h_cnt < X_OFF+(64<<SCALE_LOG2)` and `Y_OFF ≤ v_cnt < Y_OFF+(32<<SCALE_LOG2)`, with both counters in the active region.
- `col = (h_cnt-X_OFF)>>SCALE_LOG2` and `row = (v_cnt-Y_OFF)>>SCALE_LOG2`, truncated to 6 and 5 bits.
- `rom_ad` is registered. It equals `{row,col}` when `in_win`, otherwise 0.
- Stage flags `{hs, vs, de, in_win}` travel through a delay line of depth ROM_LATENCY+1, so they align with `rom_data`. The output register then selects the colour:
  - `rom_data` when `de & in_win`;
  - `BG_COLOR` when `de & !in_win`;
  - 0 when `!de`.
- Window bounds must lie inside the active area. This is checked at elaboration; a violation is a fatal error.

## Timing
- Counter value at cycle t gives `rom_ad` at t+1, `rom_data` valid at t+1+ROM_LATENCY, and all outputs at t+2+ROM_LATENCY. Every output has the same latency.
- Reset values:
  - `h_cnt` = `v_cnt` = 0, `rom_ad` = 0.
  - All delay-stage flags inactive.
  - `hsync`/`vsync` = !SYNC_POL, `de` = 0, `r`/`g`/`b` = 0.
- Reset mid-frame: the cycle after `reset` is sampled high, every register holds its reset value. No stale pixel or sync emerges from the pipeline. The first valid pixel appears ROM_LATENCY+2 cycles after `reset` falls.
- Wrap: the last pixel of a line and the first pixel of the next line are emitted on consecutive cycles, with no gap or duplicate.
- Line and frame rate are fixed. There is no backpressure.

## Configuration
- `IMAGE_SCANNER_BORDER_EN` defined: active pixels on the one-pixel ring just outside the image window are forced to 18'h3FFFF (white). This is evaluated at counter time and carried through the delay line as an extra flag.
- Undefined: the ring shows `BG_COLOR`. No border logic or flag is synthesised.

## Structure
- Package `image_pkg`:
  - `IMG_W_LOG2=6`, `IMG_H_LOG2=5`, `ROM_AW=11`;
  - `typedef struct packed {logic [5:0] r, g, b;} rgb666_t`;
  - a helper function `total(a,b,c,d)`.
- Sub-module `video_delay`: a parameterised-depth shift register with synchronous reset-to-value, used for the flag pipeline.

## Test plan
- Default parameters, 2 frames: `hsync` low for exactly 96 cycles per 800-cycle line; `vsync` low for 2 lines per 525-line frame; `de` high for 640×480 cycles per frame.
- ROM model returning word = address: the pixel at active (64,112) gives `rom_data` = 0. At (72,112), RGB = {0,0,1}. At (575,367), the word is 11'h7FF.
- Latency check: the first `de` rise after reset is 2+ROM_LATENCY = 4 cycles after `h_cnt`=0, `v_cnt`=0 is present. Syncs stay aligned with `de` for ROM_LATENCY = 1 and 4.
- Active pixel outside the window (10,10) → RGB = `BG_COLOR`. During blanking, RGB = 0.
- Reset asserted at line 200, pixel 300, for 1 cycle → next cycle all outputs are at reset values, and timing restarts at (0,0).
- With `IMAGE_SCANNER_BORDER_EN`: pixel (63,112) and pixel (576,200) output 18'h3FFFF. Without the macro, both output `BG_COLOR`.
